// File: rtl/fifo_pkg.sv
// Shared Gray/binary helpers and defaults for the async FIFO read and write controllers.
package fifo_pkg;

  localparam int unsigned FIFO_ADDR_WIDTH = 8;
  localparam int unsigned GRAY_MAX_W      = 32;

  // Width-generic: callers zero-extend to GRAY_MAX_W and truncate the result back.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Suffix-XOR by doubling shifts; upper zero bits do not disturb narrower codes.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = g;
    for (int s = 1; s < int'(GRAY_MAX_W); s = s * 2) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bus of the async FIFO: consumer handshake, cross-domain pointers and status flags.
interface fifo_rd_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = fifo_pkg::FIFO_ADDR_WIDTH
);
  logic                  r_en;
  logic [ADDR_WIDTH:0]   g_wptr_async;
  logic                  underflow_clr;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [ADDR_WIDTH:0]   g_rptr;
  logic                  rd_fire;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   rd_count;
  logic                  underflow;

  modport master (
    output r_en, g_wptr_async, underflow_clr,
    input  raddr, g_rptr, rd_fire, empty, almost_empty, rd_count, underflow
  );

  modport slave (
    input  r_en, g_wptr_async, underflow_clr,
    output raddr, g_rptr, rd_fire, empty, almost_empty, rd_count, underflow
  );
endinterface

// File: rtl/gray_sync.sv
// Multi-stage flop chain carrying a Gray pointer into another clock domain.
module gray_sync #(
  parameter int unsigned WIDTH  = 9,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < int'(STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side controller: syncs the write pointer, owns the read pointers and
// produces registered empty / almost-empty / count plus a sticky underflow flag.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = FIFO_ADDR_WIDTH,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AE_THRESH   = 128
) (
  input  logic           rclk,
  input  logic           rrst_n,
  fifo_rd_ctrl_if.slave  bus
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic [PW-1:0] g_wptr_sync;
  logic [PW-1:0] b_wptr_sync;
  logic [PW-1:0] b_rptr_q, b_rptr_d;
  logic [PW-1:0] g_rptr_q, g_rptr_d;
  logic [PW-1:0] count_q,  count_d;
  logic          empty_q,  empty_d;
  logic          ae_q,     ae_d;
  logic          uf_q,     uf_d;
  logic          rd_fire_c;

  gray_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk   (rclk),
    .rst_n (rrst_n),
    .d_i   (bus.g_wptr_async),
    .q_o   (g_wptr_sync)
  );

  assign b_wptr_sync = PW'(gray2bin(GRAY_MAX_W'(g_wptr_sync)));
  assign rd_fire_c   = bus.r_en & ~empty_q;

  // Flags are computed from the post-read pointer so empty asserts on the last read's edge.
  always_comb begin
    b_rptr_d = b_rptr_q;
    g_rptr_d = g_rptr_q;
    count_d  = count_q;
    empty_d  = empty_q;
    ae_d     = ae_q;
    uf_d     = uf_q;

    b_rptr_d = b_rptr_q + PW'(rd_fire_c);
    g_rptr_d = PW'(bin2gray(GRAY_MAX_W'(b_rptr_d)));
    count_d  = b_wptr_sync - b_rptr_d;
    empty_d  = (g_rptr_d == g_wptr_sync);
    ae_d     = (count_d <= PW'(AE_THRESH));

    if (bus.r_en && empty_q) begin
      uf_d = 1'b1;
    end else if (bus.underflow_clr) begin
      uf_d = 1'b0;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      b_rptr_q <= '0;
      g_rptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      ae_q     <= 1'b1;
      uf_q     <= 1'b0;
    end else begin
      b_rptr_q <= b_rptr_d;
      g_rptr_q <= g_rptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      ae_q     <= ae_d;
      uf_q     <= uf_d;
    end
  end

  assign bus.raddr        = b_rptr_q[ADDR_WIDTH-1:0];
  assign bus.g_rptr       = g_rptr_q;
  assign bus.rd_fire      = rd_fire_c;
  assign bus.empty        = empty_q;
  assign bus.almost_empty = ae_q;
  assign bus.rd_count     = count_q;
  assign bus.underflow    = uf_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl: a word-count model predicts every cycle's outputs.
module tb_fifo_rd_ctrl;

  localparam int unsigned AW  = 8;
  localparam int unsigned PW  = AW + 1;
  localparam int          MOD = 512;
  localparam int          AE  = 128;

  logic rclk = 1'b0;
  logic rrst_n;
  always #5 rclk = ~rclk;

  fifo_rd_ctrl_if #(.ADDR_WIDTH(AW)) bus();

  fifo_rd_ctrl #(
    .ADDR_WIDTH  (AW),
    .SYNC_STAGES (2),
    .AE_THRESH   (AE)
  ) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .bus    (bus)
  );

  typedef struct { bit fire; int raddr; } pre_t;
  typedef struct { int empty; int ae; int count; int grptr; int raddr; int uf; } post_t;

  pre_t  pre_q[$];
  post_t post_q[$];
  int    hist[$];

  int n_cmp = 0;
  int n_err = 0;

  int m_rp;
  int w;
  int m_uf;
  bit m_empty;

  function automatic int gray(int x);
    return x ^ (x >> 1);
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_rp    = 0;
    m_empty = 1'b1;
    m_uf    = 0;
    w       = 0;
    hist    = {0, 0};
  endtask

  // Drive one cycle's inputs and predict what the next rising edge must produce.
  task automatic step(bit re, int wb, bit clr);
    pre_t  p;
    post_t e;
    int    vis;
    int    cnt;
    bit    fire;
    w = wb % MOD;
    bus.r_en          = re;
    bus.g_wptr_async  = PW'(gray(w));
    bus.underflow_clr = clr;
    #1;
    fire    = re && !m_empty;
    p.fire  = fire;
    p.raddr = m_rp % 256;
    pre_q.push_back(p);
    hist.push_back(w);
    vis = hist.pop_front();
    if (re && m_empty) m_uf = 1;
    else if (clr)      m_uf = 0;
    if (fire) m_rp = (m_rp + 1) % MOD;
    cnt     = (vis + MOD - m_rp) % MOD;
    m_empty = (cnt == 0);
    e.empty = m_empty ? 1 : 0;
    e.ae    = (cnt <= AE) ? 1 : 0;
    e.count = cnt;
    e.grptr = gray(m_rp);
    e.raddr = m_rp % 256;
    e.uf    = m_uf;
    post_q.push_back(e);
  endtask

  task automatic cycle(bit re, int wb, bit clr);
    @(negedge rclk);
    step(re, wb, clr);
  endtask

  task automatic check_reset_values(string tag);
    chk({tag, "_empty"},        int'(bus.empty),        1);
    chk({tag, "_almost_empty"}, int'(bus.almost_empty), 1);
    chk({tag, "_raddr"},        int'(bus.raddr),        0);
    chk({tag, "_g_rptr"},       int'(bus.g_rptr),       0);
    chk({tag, "_rd_count"},     int'(bus.rd_count),     0);
    chk({tag, "_underflow"},    int'(bus.underflow),    0);
  endtask

  // Reset lands between edges and is checked before any clock edge occurs.
  task automatic do_reset();
    @(posedge rclk);
    #3;
    rrst_n            = 1'b0;
    bus.r_en          = 1'b0;
    bus.g_wptr_async  = '0;
    bus.underflow_clr = 1'b0;
    #1;
    check_reset_values("midreset");
    @(negedge rclk);
    rrst_n = 1'b1;
    model_reset();
    step(1'b0, 0, 1'b0);
  endtask

  initial begin : monitor
    pre_t  p;
    post_t e;
    forever begin
      @(negedge rclk);
      #2;
      if (pre_q.size() > 0) begin
        p = pre_q.pop_front();
        chk("rd_fire", int'(bus.rd_fire), int'(p.fire));
        if (p.fire) chk("raddr_at_fire", int'(bus.raddr), p.raddr);
      end
      @(posedge rclk);
      #1;
      if (post_q.size() > 0) begin
        e = post_q.pop_front();
        chk("empty",        int'(bus.empty),        e.empty);
        chk("almost_empty", int'(bus.almost_empty), e.ae);
        chk("rd_count",     int'(bus.rd_count),     e.count);
        chk("g_rptr",       int'(bus.g_rptr),       e.grptr);
        chk("raddr",        int'(bus.raddr),        e.raddr);
        chk("underflow",    int'(bus.underflow),    e.uf);
      end
    end
  end

  initial begin : driver
    int occ;
    int nw;
    int rd_pct;
    int tgt;
    int gap;

    rrst_n            = 1'b1;
    bus.r_en          = 1'b0;
    bus.g_wptr_async  = '0;
    bus.underflow_clr = 1'b0;
    #2;
    rrst_n = 1'b0;
    #1;
    check_reset_values("reset");
    @(negedge rclk);
    rrst_n = 1'b1;
    model_reset();
    step(1'b0, 0, 1'b0);

    // Single word arrives; then read it, over-read, and clear underflow.
    repeat (4) cycle(1'b0, 1, 1'b0);
    repeat (3) cycle(1'b1, 1, 1'b0);
    cycle(1'b0, 1, 1'b1);
    cycle(1'b0, 1, 1'b0);
    repeat (2) cycle(1'b0, 3, 1'b0);
    repeat (3) cycle(1'b1, 3, 1'b0);
    do_reset();

    // Four words read back-to-back with r_en held, then clear and clear-vs-set.
    repeat (10) cycle(1'b1, 4, 1'b0);
    cycle(1'b0, 4, 1'b1);
    cycle(1'b0, 4, 1'b0);
    repeat (2) cycle(1'b1, 4, 1'b1);
    cycle(1'b0, 4, 1'b0);

    // Almost-empty threshold crossing: 200 words, 72 reads bring count to 128.
    repeat (3)   cycle(1'b0, 204, 1'b0);
    repeat (72)  cycle(1'b1, 204, 1'b0);
    repeat (140) cycle(1'b1, 204, 1'b0);

    // Randomised traffic with alternating read pressure and one mid-traffic reset.
    for (int i = 0; i < 2500; i++) begin
      if (i == 1500) do_reset();
      occ    = (w + MOD - m_rp) % MOD;
      rd_pct = ((i / 250) % 2 == 1) ? 80 : 40;
      nw     = w;
      if (occ < 256) begin
        gap = 256 - occ;
        nw  = w + (($urandom_range(0, 2) > gap) ? gap : int'($urandom_range(0, 2)));
      end
      cycle($urandom_range(0, 99) < rd_pct, nw, $urandom_range(0, 9) == 0);
    end

    // Drain, then walk the read pointer up to 511 and cross the wrap point.
    repeat (260) cycle(1'b1, w, 1'b0);
    while (m_rp != 511) begin
      tgt = m_rp + (((511 - m_rp) > 200) ? 200 : (511 - m_rp));
      repeat (205) cycle(1'b1, tgt, 1'b0);
    end
    repeat (3) cycle(1'b0, 512, 1'b0);
    cycle(1'b1, 512, 1'b0);
    repeat (3) cycle(1'b0, 512, 1'b0);

    repeat (3) @(negedge rclk);
    chk("queues_drained", pre_q.size() + post_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
